// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the adder library.
//   state_t     - serial_adder sequencer states
//   ADDER_WIDTH - default operand width
package adder_pkg;

  localparam int ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder: combinational one-bit full adder built from two half adders.
//   i_a, i_b : operand bits
//   i_cin    : carry in
//   o_sum    : sum bit
//   o_cout   : carry out
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_sum(w_s0),  .o_carry(w_c0));
  half_adder u_ha1 (.i_a(w_s0), .i_b(i_cin), .o_sum(o_sum), .o_carry(w_c1));

  // The two half-adder carries can never both be 1, so OR suffices.
  assign o_cout = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// half_adder: combinational one-bit half adder.
//   i_a, i_b : operand bits
//   o_sum    : i_a ^ i_b
//   o_carry  : i_a & i_b
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, LSB first, one bit per clock.
//   wire_clk   : clock (rising edge)
//   wire_rst   : synchronous active-high reset
//   wire_start : begin an addition (accepted only in IDLE)
//   wire_a/b   : operands, sampled on the accepting edge
//   wire_busy  : high in RUN and DONE
//   wire_done  : one-cycle pulse, result valid
//   wire_sum   : A+B mod 2^WIDTH, updated only on DONE entry
//   wire_carry : carry out of bit WIDTH-1, updated only on DONE entry
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             wire_clk,
  input  logic             wire_rst,
  input  logic             wire_start,
  input  logic [WIDTH-1:0] wire_a,
  input  logic [WIDTH-1:0] wire_b,
  output logic             wire_busy,
  output logic             wire_done,
  output logic [WIDTH-1:0] wire_sum,
  output logic             wire_carry
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sr_next;

  full_adder u_fa (
    .i_a   (r_sa[0]),
    .i_b   (r_sb[0]),
    .i_cin (r_c),
    .o_sum (w_s),
    .o_cout(w_co)
  );

  // Result fills from the top; after WIDTH shifts bit 0 holds the LSB.
  assign w_sr_next = {w_s, r_sr[WIDTH-1:1]};

  always_ff @(posedge wire_clk) begin
    if (wire_rst) begin
      r_state <= ST_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wire_start) begin
            r_sa    <= wire_a;
            r_sb    <= wire_b;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sr <= w_sr_next;
          r_sa <= r_sa >> 1;
          r_sb <= r_sb >> 1;
          r_c  <= w_co;
          if (r_cnt == LAST) begin
            // Final bit: publish the completed word, counter stays put.
            r_sum   <= w_sr_next;
            r_carry <= w_co;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wire_busy  = r_busy;
  assign wire_done  = r_done;
  assign wire_sum   = r_sum;
  assign wire_carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] prev_sum;
  logic       prev_carry;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .wire_clk  (clk),
    .wire_rst  (rst),
    .wire_start(start),
    .wire_a    (a_i),
    .wire_b    (b_i),
    .wire_busy (busy),
    .wire_done (done),
    .wire_sum  (sum),
    .wire_carry(carry)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One addition with busy/done/latency/hold checks; operands scrambled after E0.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic ec, input string nm);
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1; a_i = a; b_i = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a_i = 8'($urandom); b_i = 8'($urandom);
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      if (done) seen = 1;
      else begin
        chk({nm, " hold_sum"}, 32'(sum), 32'(prev_sum));
        chk({nm, " hold_carry"}, 32'(carry), 32'(prev_carry));
        chk({nm, " busy_run"}, 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
    end
    chk({nm, " done_seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'd8);
    chk({nm, " sum"}, 32'(sum), 32'(es));
    chk({nm, " carry"}, 32'(carry), 32'(ec));
    chk({nm, " busy_done"}, 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk({nm, " done_drop"}, 32'(done), 32'd0);
    chk({nm, " busy_drop"}, 32'(busy), 32'd0);
    chk({nm, " sum_keep"}, 32'(sum), 32'(es));
    prev_sum = es;
    prev_carry = ec;
  endtask

  initial begin
    int dones;
    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[5] = '{8'h3C, 8'hC3, 8'hFF, 1'b0};
    vecs[6] = '{8'h01, 8'h01, 8'h02, 1'b0};
    vecs[7] = '{8'h6D, 8'h2B, 8'h98, 1'b0};

    // Reset with start asserted: reset must win.
    rst = 1'b1; start = 1'b1; a_i = 8'h77; b_i = 8'h66;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst sum", 32'(sum), 32'd0);
    chk("rst carry", 32'(carry), 32'd0);
    rst = 1'b0; start = 1'b0;
    prev_sum = 8'h00; prev_carry = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, $sformatf("vec%0d", i));

    // Operands churn and start pulses during RUN/DONE: one result, one pulse.
    @(negedge clk);
    start = 1'b1; a_i = 8'h12; b_i = 8'h34;
    @(posedge clk);
    dones = 0;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        chk("churn done_at", 32'(s), 32'd8);
        chk("churn sum", 32'(sum), 32'h46);
        chk("churn carry", 32'(carry), 32'd0);
      end else if (s < 8) begin
        chk("churn hold", 32'(sum), 32'(prev_sum));
      end
      a_i = 8'($urandom); b_i = 8'($urandom);
      start = (s < 8) ? s[0] : (s == 8);
    end
    start = 1'b0;
    chk("churn pulses", 32'(dones), 32'd1);
    prev_sum = 8'h46; prev_carry = 1'b0;

    // Reset mid-RUN at counter=4 aborts and clears outputs.
    @(negedge clk);
    start = 1'b1; a_i = 8'h55; b_i = 8'h11;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort sum", 32'(sum), 32'd0);
    chk("abort carry", 32'(carry), 32'd0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort no_done", 32'(dones), 32'd0);
    prev_sum = 8'h00; prev_carry = 1'b0;
    run_op(8'h7F, 8'h01, 8'h80, 1'b0, "post_abort");

    // Start held high: accepted every WIDTH+2 = 10 cycles.
    @(negedge clk);
    start = 1'b1; a_i = 8'h01; b_i = 8'h01;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stream done k%0d", k), 32'(done), 32'((k % 10) == 8));
      chk($sformatf("stream busy k%0d", k), 32'(busy), 32'((k % 10) != 9));
      if ((k % 10) == 8) begin
        chk($sformatf("stream sum k%0d", k), 32'(sum), 32'h02);
        chk($sformatf("stream carry k%0d", k), 32'(carry), 32'd0);
      end
    end
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder that sums two WIDTH-bit operands LSB-first, one bit per clock, using a single full-adder cell and a carry flip-flop. It sits directly downstream of the combinational half-adder cell and consumes it: two half-adder instances form the full-adder slice, and this block supplies the sequencing, carry storage and result shifting around it. It trades latency for area in the adder library.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- wire_clk  input  1  single clock; all state updates on the rising edge.
- wire_rst  input  1  synchronous, active-high reset.
- wire_start  input  1  request to begin an addition; accepted only in IDLE.
- wire_a  input  WIDTH  operand A; sampled on the accepting edge only.
- wire_b  input  WIDTH  operand B; sampled on the accepting edge only.
- wire_busy  output  1  high in RUN and DONE; low in IDLE.
- wire_done  output  1  one-cycle pulse; result valid.
- wire_sum  output  WIDTH  registered sum, A+B mod 2^WIDTH.
- wire_carry  output  1  registered carry out of bit WIDTH-1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - wire_start=1 latches wire_a and wire_b into shift registers sa and sb.
  - Internal carry flop clears to 0; bit counter clears to 0; next state RUN.
  - wire_start=0: remain in IDLE.
- RUN, each cycle:
  - The full-adder slice takes sa[0], sb[0] and the carry flop.
  - Sum bit shifts into the MSB of an internal result register sr (right shift); sa and sb shift right.
  - Carry flop takes the slice carry; counter increments.
  - On the cycle with counter = WIDTH-1: wire_sum is loaded with the completed sr, wire_carry with the final carry; next state DONE.
- DONE: wire_done=1 for exactly one cycle; next state IDLE unconditionally.
- wire_start is ignored in RUN and DONE; there is no queueing.
- wire_sum and wire_carry change only on the DONE-entry edge. They hold their values through IDLE and the whole of the next operation.
- Arithmetic: unsigned; the WIDTH+1-bit result is {wire_carry, wire_sum}. No carry-in port.
- Counter width is $clog2(WIDTH). Terminal compare is against WIDTH-1, with no wrap beyond it.

## Timing
- Reset values: state IDLE; wire_busy 0, wire_done 0, wire_sum 0, wire_carry 0; internal sa, sb, sr, carry and counter all 0.
- Reset has priority over every other event, including start on the same edge.
- Reset mid-RUN or in DONE aborts the operation: no done pulse, and wire_sum/wire_carry return to 0.
- Latency: start accepted at edge E0. Bits are processed at edges E1..E_WIDTH. wire_done and the new wire_sum/wire_carry are visible after edge E_WIDTH. wire_done drops after E_WIDTH+1.
- wire_busy rises after E0 and falls after E_WIDTH+1.
- Throughput: wire_start held high continuously is accepted once every WIDTH+2 cycles.
- Operand inputs may change freely after the accepting edge.

## Structure
- Shared package/include adder_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default width constant ADDER_WIDTH=8.
- One sub-module: full_adder. It is built from two half_adder instances plus an OR of their carries, and is instantiated once in serial_adder.
- All sequential logic lives in serial_adder; full_adder is purely combinational.

## Test plan
- WIDTH=8, a=0x00, b=0x00, start one cycle -> wire_done pulses one cycle after edge E8; wire_sum=0x00, wire_carry=0.
- a=0xFF, b=0x01 -> wire_sum=0x00, wire_carry=1. Carry ripples through all 8 bits.
- a=0xA5, b=0x5A -> wire_sum=0xFF, wire_carry=0. a=0x80, b=0x80 -> wire_sum=0x00, wire_carry=1.
- Start with a=0x12, b=0x34; change a/b every cycle and pulse wire_start again during RUN and DONE:
  - result 0x46, carry 0;
  - exactly one done pulse;
  - wire_sum holds its prior value until the DONE-entry edge.
- Assert wire_rst at counter=4 mid-RUN -> outputs 0, state IDLE, no done pulse. A new start then completes normally (0x7F+0x01 -> 0x80, carry 0).
- wire_start held high for 30 cycles with a=0x01, b=0x01 -> done pulses every 10 cycles; each result 0x02.
